wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Single-transaction Wishbone initiator (bus master).
- Converts a valid/ready command stream into classic Wishbone read/write cycles toward slaves such as the GPIO and timer peripherals.
- Returns read data and a completion status on a valid/ready response stream.
- Used by debug/UART bridges and test logic to drive the SoC bus without a CPU.

Parameters:
- TIMEOUT, 255: bus cycles to wait for ack before aborting; 0 disables the timeout.
- TW, 8: width of the timeout counter; TIMEOUT must fit in TW bits.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
- cmd_we  input  1  1=write, 0=read
- cmd_adr  input  32  byte address
- cmd_sel  input  4  byte lane select
- cmd_dat  input  32  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
- rsp_dat  output  32  read data (0 for writes and errors)
- rsp_err  output  1  1 = transaction aborted (timeout, or bus error when enabled)
- wb_cyc_o  output  1  Wishbone cycle
- wb_stb_o  output  1  Wishbone strobe
- wb_we_o  output  1  Wishbone write enable
- wb_adr_o  output  32  Wishbone address
- wb_sel_o  output  4  Wishbone byte select
- wb_dat_o  output  32  Wishbone write data
- wb_dat_i  input  32  Wishbone read data
- wb_ack_i  input  1  Wishbone acknowledge

Behaviour:
- One clock, clk. reset is synchronous and active-low: reset==0 sampled at a posedge resets the block.
- Reset values:
  - state=IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_dat=0.
  - wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_sel_o=0, wb_dat_o=0, timeout counter=0.
- All outputs are registered. cmd_ready = (state==IDLE).
- FSM states: IDLE, BUS, RESP.
  - IDLE: on cmd_valid at edge N, latch adr/sel/we/dat into the wb_*_o registers. Set cyc=stb=1 from cycle N+1, clear counter, go BUS.
  - BUS: cyc/stb and all wb_*_o held stable until termination.
    - wb_ack_i=1 sampled: drop cyc/stb at that edge. rsp_dat=wb_dat_i for reads, 0 for writes. rsp_err=0, rsp_valid=1, go RESP.
    - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: drop cyc/stb, rsp_dat=0, rsp_err=1, rsp_valid=1, go RESP.
    - Else counter+1.
    - Ack and timeout in the same cycle: ack wins, rsp_err=0.
  - RESP: rsp_valid, rsp_dat and rsp_err held until rsp_ready. On rsp_valid & rsp_ready: rsp_valid=0, go IDLE (cmd_ready=1 next cycle). No new command is accepted in BUS or RESP.
- Latency against a slave acking one cycle after stb:
  - accept at edge N, cyc/stb high during N+1, ack sampled at edge N+2, rsp_valid high from N+3.
  - Minimum command-to-command spacing is 4 cycles when rsp_ready is held high.
- wb_ack_i outside BUS is ignored.
- Counter saturates logically; it never wraps, because expiry exits BUS.
- Reset while in BUS: cyc/stb drop at the reset edge. The pending transaction is discarded with no response; the slave sees the cycle abandoned.

Optional Feature:
- Macro: WB_CMD_MASTER_ERR_EN.
- Defined: adds input port wb_err_i (1 bit). In BUS, wb_err_i=1 terminates the cycle like ack, with rsp_err=1 and rsp_dat=0. Priority is ack > err > timeout.
- Undefined: no wb_err_i port; rsp_err is set only by timeout.

Test Plan:
- Write, single-cycle-ack model slave: cmd_we=1, adr=0x14, sel=0xF, dat=0xA5A5_0001 -> cyc/stb/we high exactly 2 cycles with adr=0x14 and dat stable; rsp_valid at N+3, rsp_err=0, rsp_dat=0.
- Read: slave returns 0xDEAD_BEEF for adr=0x10 -> rsp_dat=0xDEAD_BEEF, rsp_err=0; cmd_ready low from N+1 until the cycle after the rsp handshake.
- Timeout: TIMEOUT=4, slave never acks -> cyc/stb high exactly 4 cycles, then rsp_valid=1, rsp_err=1, rsp_dat=0.
- Backpressure: hold rsp_ready=0 for 10 cycles after a read of 0x1234_5678 -> rsp_valid and rsp_dat stable, cmd_ready=0, second cmd_valid not accepted; release -> IDLE next cycle and the second command is accepted.
- Reset mid-cycle: drive reset=0 while in BUS -> at the next edge cyc=stb=0, rsp_valid=0, cmd_ready=1; no response emitted.
- With WB_CMD_MASTER_ERR_EN: slave asserts wb_err_i on the 2nd BUS cycle -> rsp_err=1, rsp_dat=0; ack and err asserted together -> rsp_err=0.

Source files
------------

// File: rtl/wb_cmd_master.sv
// ============================================================================
// wb_cmd_master
// ----------------------------------------------------------------------------
// Single-transaction Wishbone initiator. A command accepted on the cmd stream
// becomes one classic Wishbone read or write cycle. The completion status and
// any read data are returned on the rsp stream. Only one transaction is in
// flight at a time.
//
// Handshake semantics (both streams): a transfer happens on a rising clk edge
// where valid & ready are both 1. A producer holds valid and its payload
// stable until that transfer. ready may be asserted before valid.
//
// Parameters
//   TIMEOUT : bus cycles to wait for an ack before aborting (0 = wait forever)
//   TW      : width of the timeout counter (TIMEOUT must fit in TW bits)
//
// Ports
//   clk, reset          : clock, synchronous active-low reset
//   cmd_valid/cmd_ready : command handshake (cmd_ready is high only in IDLE)
//   cmd_we/adr/sel/dat  : command payload (write enable, address, lanes, data)
//   rsp_valid/rsp_ready : response handshake
//   rsp_dat, rsp_err    : read data (0 for writes/errors), abort flag
//   wb_*_o / wb_*_i     : Wishbone initiator interface
//   wb_err_i            : bus error input, present only with the macro below
//   dbg_state           : current FSM state (0=IDLE, 1=BUS, 2=RESP)
//
// Build option
//   WB_CMD_MASTER_ERR_EN : adds wb_err_i. Priority is ack > err > timeout.
// ============================================================================
module wb_cmd_master #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
`ifdef WB_CMD_MASTER_ERR_EN
    input  logic        wb_err_i,
`endif
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam bit          LP_TO_EN = (TIMEOUT != 0);
    // Last counter value before expiry. When TIMEOUT is 0 it is unused.
    localparam logic [TW-1:0] LP_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        r_state;
    logic          r_cmd_ready;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_dat;
    logic          r_rsp_err;
    logic          r_cyc;
    logic          r_we;
    logic [31:0]   r_adr;
    logic [3:0]    r_sel;
    logic [31:0]   r_dat;
    logic [TW-1:0] r_cnt;

    logic w_err;
    logic w_expire;

`ifdef WB_CMD_MASTER_ERR_EN
    assign w_err = wb_err_i;
`else
    assign w_err = 1'b0;
`endif

    assign w_expire = LP_TO_EN && (r_cnt == LP_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= 32'd0;
            r_sel       <= 4'd0;
            r_dat       <= 32'd0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_we        <= cmd_we;
                        r_adr       <= cmd_adr;
                        r_sel       <= cmd_sel;
                        r_dat       <= cmd_dat;
                        r_cyc       <= 1'b1;
                        r_cnt       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wb_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_rsp_dat   <= r_we ? 32'd0 : wb_dat_i;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (w_err || w_expire) begin
                        r_cyc       <= 1'b0;
                        r_rsp_dat   <= 32'd0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        // Never wraps: reaching LP_LAST leaves BUS.
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_cyc       <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;   // single-beat cycles: stb tracks cyc
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_sel_o  = r_sel;
    assign wb_dat_o  = r_dat;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed commands, a model slave with registered
// ack/err, and a response scoreboard that pops expected {err,dat} entries.
module tb_wb_cmd_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q[$];

  // expected bus fields for the transaction in flight
  logic        exp_we;
  logic [31:0] exp_adr;
  logic [3:0]  exp_sel;
  logic [31:0] exp_dat;

  int  cyc_len = 0;
  int  last_cyc_len = 0;
  bit  ready_pending = 0;

  // model slave controls
  bit   ack_en = 1;
  bit   err_en = 0;
  logic r_resp = 1'b0;

  wb_cmd_master #(.TIMEOUT(4), .TW(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
`ifdef WB_CMD_MASTER_ERR_EN
    .wb_err_i(wb_err_i),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model slave: responds one cycle after seeing stb
  always @(posedge clk) r_resp <= wb_cyc_o & wb_stb_o & ~r_resp & (ack_en | err_en);
  assign wb_ack_i = r_resp & ack_en;
  assign wb_err_i = r_resp & err_en;
  always_comb begin
    case (wb_adr_o)
      32'h10:  wb_dat_i = 32'hDEAD_BEEF;
      32'h18:  wb_dat_i = 32'h1234_5678;
      default: wb_dat_i = 32'h0BAD_0000 | wb_adr_o;
    endcase
  end

  // bus monitor
  always @(negedge clk) begin
    if (wb_cyc_o) begin
      cyc_len++;
      check("bus_stb", {31'd0, wb_stb_o}, 32'd1);
      check("bus_we", {31'd0, wb_we_o}, {31'd0, exp_we});
      check("bus_adr", wb_adr_o, exp_adr);
      check("bus_sel", {28'd0, wb_sel_o}, {28'd0, exp_sel});
      check("bus_dat", wb_dat_o, exp_dat);
    end else if (cyc_len != 0) begin
      last_cyc_len = cyc_len;
      cyc_len = 0;
    end
    if (wb_cyc_o || rsp_valid)
      check("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
  end

  // response monitor / scoreboard
  always @(negedge clk) begin
    logic [32:0] e;
    if (ready_pending) begin
      check("ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
      ready_pending = 0;
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
        check("rsp_dat", rsp_dat, e[31:0]);
      end
      ready_pending = 1;
    end
  end

  // driver tasks (called after posedge + 1)
  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input bit push, input logic [32:0] exp_rsp);
    bit ok;
    exp_we = we; exp_adr = adr; exp_sel = sel; exp_dat = dat;
    cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
    cmd_valid = 1'b1;
    if (push) exp_q.push_back(exp_rsp);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!ok) check("cmd_accept_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("rsp_wait_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    reset = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0;
    cmd_dat = '0; rsp_ready = 1'b1;
    exp_we = 1'b0; exp_adr = '0; exp_sel = '0; exp_dat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    check("rst_we", {31'd0, wb_we_o}, 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // write, single-cycle ack slave
    send_cmd(1'b1, 32'h14, 4'hF, 32'hA5A5_0001, 1, {1'b0, 32'h0});
    wait_rsp();
    check("wr_cyc_len", last_cyc_len, 32'd2);

    // read
    send_cmd(1'b0, 32'h10, 4'h3, 32'h0, 1, {1'b0, 32'hDEAD_BEEF});
    wait_rsp();
    check("rd_cyc_len", last_cyc_len, 32'd2);

    // timeout: slave never answers
    ack_en = 0;
    send_cmd(1'b0, 32'h20, 4'hF, 32'h5555_AAAA, 1, {1'b1, 32'h0});
    wait_rsp();
    check("to_cyc_len", last_cyc_len, 32'd4);
    ack_en = 1;

    // backpressure
    rsp_ready = 1'b0;
    send_cmd(1'b0, 32'h18, 4'hF, 32'h0, 1, {1'b0, 32'h1234_5678});
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("bp_rsp_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    exp_we = 1'b0; exp_adr = 32'h10; exp_sel = 4'h1; exp_dat = 32'h0;
    cmd_we = 1'b0; cmd_adr = 32'h10; cmd_sel = 4'h1; cmd_dat = 32'h0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_dat", rsp_dat, 32'h1234_5678);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_no_cyc", {31'd0, wb_cyc_o}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    @(posedge clk); #1;
    check("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
    check("bp_idle_cyc", {31'd0, wb_cyc_o}, 32'd0);
    @(posedge clk); #1;
    check("bp_second_cyc", {31'd0, wb_cyc_o}, 32'd1);
    check("bp_second_adr", wb_adr_o, 32'h10);
    cmd_valid = 1'b0;
    wait_rsp();

    // reset while in BUS
    ack_en = 0;
    send_cmd(1'b0, 32'h30, 4'hF, 32'h0, 0, 33'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_in_bus", {31'd0, wb_cyc_o}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("mid_stb", {31'd0, wb_stb_o}, 32'd0);
    check("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b1;
    ack_en = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // a write after the abandoned cycle still works
    send_cmd(1'b1, 32'h44, 4'hC, 32'h0F0F_1234, 1, {1'b0, 32'h0});
    wait_rsp();

`ifdef WB_CMD_MASTER_ERR_EN
    ack_en = 0; err_en = 1;
    send_cmd(1'b0, 32'h10, 4'hF, 32'h0, 1, {1'b1, 32'h0});
    wait_rsp();
    check("err_cyc_len", last_cyc_len, 32'd2);
    ack_en = 1; err_en = 1;
    send_cmd(1'b0, 32'h10, 4'hF, 32'h0, 1, {1'b0, 32'hDEAD_BEEF});
    wait_rsp();
    ack_en = 1; err_en = 0;
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
